// File: rtl/mccp_pkg.sv
// Shared definitions for the MCCP memory arbiter: FSM state encoding and default sizes.
package mccp_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CORES    = 4;
    localparam int DEF_CORE_NUM = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection among eligible cores.
// Round-robin from a pointer when MEM_ARB_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
module rr_picker #(
    parameter int CORES    = 4,
    parameter int CORE_NUM = 2
) (
    input  logic [CORES-1:0]    eligible,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [CORE_NUM-1:0] ptr,
`endif
    output logic                found,
    output logic [CORE_NUM-1:0] winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    int cand;

    // Scan offsets from farthest to nearest so the core closest to ptr is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = CORES - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % CORES;
            if (eligible[CORE_NUM'(cand)]) begin
                found  = 1'b1;
                winner = CORE_NUM'(cand);
            end
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = CORES - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found  = 1'b1;
                winner = CORE_NUM'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data RAM between CORES cores, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module mem_arbiter
    import mccp_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CORES       = DEF_CORES,
    parameter int CORE_NUM    = DEF_CORE_NUM,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CORES-1:0]       core_request,
    input  logic [CORES-1:0]       core_wren,
    input  logic [CORES*WIDTH-1:0] core_address,
    input  logic [CORES*WIDTH-1:0] core_writedata,
    output logic [CORES-1:0]       core_response,
    output logic [WIDTH-1:0]       core_readdata,
    output logic [WIDTH-1:0]       mem_address,
    output logic [WIDTH-1:0]       mem_writedata,
    output logic                   mem_wren,
    output logic                   mem_rden,
    input  logic [WIDTH-1:0]       mem_readdata,
    output logic [CORE_NUM-1:0]    grant_idx
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_t          state, state_next;
    logic [CORES-1:0]    mask;
    logic [CORES-1:0]    eligible;
    logic [CORE_NUM-1:0] idx;
    logic [CORE_NUM-1:0] winner;
    logic                found;
    logic                lat_wren;
    logic [WIDTH-1:0]    lat_addr;
    logic [WIDTH-1:0]    lat_wdata;
    logic [WIDTH-1:0]    rdata;
    logic [CNT_W-1:0]    cnt;
    logic                capture;

    // The mask keeps a just-served core out of the very next arbitration.
    assign eligible = core_request & ~mask;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [CORE_NUM-1:0] ptr;

    rr_picker #(.CORES(CORES), .CORE_NUM(CORE_NUM)) u_picker (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == RESP) begin
            ptr <= (idx == CORE_NUM'(CORES - 1)) ? '0 : idx + 1'b1;
        end
    end
`else
    rr_picker #(.CORES(CORES), .CORE_NUM(CORE_NUM)) u_picker (
        .eligible (eligible),
        .found    (found),
        .winner   (winner)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Counter reaching 1 in WAIT means this is the cycle mem_readdata is valid.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ISSUE;
            ISSUE:   state_next = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign capture = ((state == ISSUE) && (MEM_LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            idx       <= '0;
            lat_wren  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (found) begin
                        idx       <= winner;
                        lat_wren  <= core_wren[winner];
                        lat_addr  <= core_address[winner*WIDTH +: WIDTH];
                        lat_wdata <= core_writedata[winner*WIDTH +: WIDTH];
                    end
                end
                ISSUE:   cnt  <= CNT_W'(MEM_LATENCY - 1);
                WAIT:    cnt  <= cnt - 1'b1;
                RESP:    mask <= CORES'(1) << idx;
                default: mask <= '0;
            endcase
            if (capture) rdata <= lat_wren ? '0 : mem_readdata;
        end
    end

    assign mem_address   = lat_addr;
    assign mem_writedata = lat_wdata;
    assign mem_wren      = (state == ISSUE) && lat_wren;
    assign mem_rden      = (state == ISSUE) && !lat_wren;
    assign core_response = (state == RESP) ? (CORES'(1) << idx) : '0;
    assign core_readdata = (state == RESP) ? rdata : '0;
    assign grant_idx     = idx;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-core request queues, RAM model, response/memory monitors.
module tb_mem_arbiter;

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          core;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } mem_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   core_request = '0;
    logic [3:0]   core_wren = '0;
    logic [127:0] core_address = '0;
    logic [127:0] core_writedata = '0;
    logic [3:0]   core_response;
    logic [31:0]  core_readdata;
    logic [31:0]  mem_address;
    logic [31:0]  mem_writedata;
    logic         mem_wren;
    logic         mem_rden;
    logic [31:0]  mem_readdata = '0;
    logic [1:0]   grant_idx;

    logic [3:0]   l1_request = '0;
    logic [3:0]   l1_wren = '0;
    logic [127:0] l1_address = '0;
    logic [127:0] l1_writedata = '0;
    logic [3:0]   l1_response;
    logic [31:0]  l1_readdata;
    logic [31:0]  l1_mem_address;
    logic [31:0]  l1_mem_writedata;
    logic         l1_mem_wren;
    logic         l1_mem_rden;
    logic [31:0]  l1_mem_readdata;
    logic [1:0]   l1_grant_idx;

    logic [31:0]  ram [0:255];
    txn_t         core_q [4][$];
    resp_t        resp_q [$];
    mem_t         mem_q [$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    mem_arbiter u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_request   (core_request),
        .core_wren      (core_wren),
        .core_address   (core_address),
        .core_writedata (core_writedata),
        .core_response  (core_response),
        .core_readdata  (core_readdata),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_wren       (mem_wren),
        .mem_rden       (mem_rden),
        .mem_readdata   (mem_readdata),
        .grant_idx      (grant_idx)
    );

    mem_arbiter #(.MEM_LATENCY(1)) u_dut_lat1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_request   (l1_request),
        .core_wren      (l1_wren),
        .core_address   (l1_address),
        .core_writedata (l1_writedata),
        .core_response  (l1_response),
        .core_readdata  (l1_readdata),
        .mem_address    (l1_mem_address),
        .mem_writedata  (l1_mem_writedata),
        .mem_wren       (l1_mem_wren),
        .mem_rden       (l1_mem_rden),
        .mem_readdata   (l1_mem_readdata),
        .grant_idx      (l1_grant_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data appears the cycle after the read strobe (latency 2 timing).
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address[9:2]] <= mem_writedata;
        if (mem_rden) mem_readdata <= ram[mem_address[9:2]];
    end

    assign l1_mem_readdata = l1_mem_address ^ 32'hA5A5_A5A5;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int core, input logic wren, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input int resp_off, input bit expect_resp);
        txn_t  t;
        resp_t r;
        mem_t  m;
        t.wren = wren; t.addr = addr; t.wdata = wdata;
        core_q[core].push_back(t);
        m.wren = wren; m.addr = addr; m.wdata = wdata; m.cyc = cyc + resp_off - 2;
        mem_q.push_back(m);
        if (expect_resp) begin
            r.core = core; r.data = exp_data; r.cyc = cyc + resp_off;
            resp_q.push_back(r);
        end
    endtask

    // Each core holds its head transaction until its response, then moves to the next one.
    task automatic driveCores();
        for (int i = 0; i < 4; i++) begin
            if (rst_n && core_response[i] && core_q[i].size() > 0) void'(core_q[i].pop_front());
            if (core_q[i].size() > 0) begin
                core_request[i]             = 1'b1;
                core_wren[i]                = core_q[i][0].wren;
                core_address[i*32 +: 32]    = core_q[i][0].addr;
                core_writedata[i*32 +: 32]  = core_q[i][0].wdata;
            end else begin
                core_request[i] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        driveCores();
    end

    // Monitor: compares every response and every memory strobe against the queued expectations.
    initial forever begin
        resp_t r;
        mem_t  m;
        @(negedge clk);
        if (rst_n && core_response != 4'b0) begin
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_response", {28'b0, core_response}, 32'h0);
            end else begin
                r = resp_q.pop_front();
                checkOutput("resp_onehot", {28'b0, core_response}, 32'(4'b0001 << r.core));
                checkOutput("resp_data", core_readdata, r.data);
                checkOutput("resp_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
        if (rst_n && (mem_wren || mem_rden)) begin
            if (mem_q.size() == 0) begin
                checkOutput("unexpected_mem_strobe", {30'b0, mem_wren, mem_rden}, 32'h0);
            end else begin
                m = mem_q.pop_front();
                checkOutput("mem_strobe", {30'b0, mem_wren, mem_rden}, {30'b0, m.wren, !m.wren});
                checkOutput("mem_address", mem_address, m.addr);
                checkOutput("mem_writedata", mem_writedata, m.wdata);
                checkOutput("mem_cycle", 32'(cyc), 32'(m.cyc));
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_core_response"}, {28'b0, core_response}, 32'h0);
        checkOutput({tag, "_core_readdata"}, core_readdata, 32'h0);
        checkOutput({tag, "_mem_strobes"}, {30'b0, mem_wren, mem_rden}, 32'h0);
        checkOutput({tag, "_mem_address"}, mem_address, 32'h0);
        checkOutput({tag, "_mem_writedata"}, mem_writedata, 32'h0);
        checkOutput({tag, "_grant_idx"}, {30'b0, grant_idx}, 32'h0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) core_q[i].delete();
        core_request = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0 || core_q[0].size() != 0 ||
                core_q[1].size() != 0 || core_q[2].size() != 0 || core_q[3].size() != 0) &&
               n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: %0d responses still pending after %0d cycles, expected 0",
                     resp_q.size(), max_cycles);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic startCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int rd_cyc;
        int rs_cyc;
        int t0;
        logic [3:0]  l1_resp_seen;
        logic [31:0] l1_data_seen;

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) ram[i] = 32'h100 + 32'(i);
        for (int i = 4; i < 8; i++) ram[i] = 32'h200 + 32'(i - 4);

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single read and single write");
        startCycle();
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3, 1'b1);
        waitDrain(40);
        startCycle();
        applyStimulus(2, 1'b1, 32'h80, 32'h1234_5678, 32'h0, 3, 1'b1);
        waitDrain(40);

        $display("[TB] four simultaneous requests");
        resetDut();
        startCycle();
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 32'h100, 3, 1'b1);
        applyStimulus(1, 1'b0, 32'h04, 32'h0, 32'h101, 7, 1'b1);
        applyStimulus(2, 1'b0, 32'h08, 32'h0, 32'h102, 11, 1'b1);
        applyStimulus(3, 1'b0, 32'h0C, 32'h0, 32'h103, 15, 1'b1);
        waitDrain(60);

        $display("[TB] chained core 0 with core 1 interleaved");
        startCycle();
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'h200, 3, 1'b1);
        applyStimulus(1, 1'b0, 32'h1C, 32'h0, 32'h203, 7, 1'b1);
        applyStimulus(0, 1'b0, 32'h14, 32'h0, 32'h201, 11, 1'b1);
        applyStimulus(0, 1'b0, 32'h18, 32'h0, 32'h202, 16, 1'b1);
        waitDrain(60);

        $display("[TB] reset during WAIT");
        startCycle();
        applyStimulus(2, 1'b0, 32'h40, 32'h0, 32'h0, 3, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        for (int i = 0; i < 4; i++) core_q[i].delete();
        core_request = '0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("midreset_no_response", {28'b0, core_response}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        startCycle();
        applyStimulus(3, 1'b1, 32'h84, 32'hCAFE_F00D, 32'h0, 3, 1'b1);
        applyStimulus(3, 1'b0, 32'h84, 32'h0, 32'hCAFE_F00D, 8, 1'b1);
        waitDrain(40);

        $display("[TB] latency 1 instance");
        startCycle();
        t0 = cyc;
        l1_request = 4'b0010;
        l1_wren = 4'b0000;
        l1_address[63:32] = 32'h20;
        rd_cyc = -1;
        rs_cyc = -1;
        l1_resp_seen = '0;
        l1_data_seen = '0;
        for (int k = 0; k < 8 && rs_cyc < 0; k++) begin
            @(negedge clk);
            if (l1_mem_rden) rd_cyc = cyc;
            if (l1_response != 4'b0) begin
                rs_cyc = cyc;
                l1_resp_seen = l1_response;
                l1_data_seen = l1_readdata;
            end
        end
        l1_request = 4'b0000;
        checkOutput("lat1_rden_cycle", 32'(rd_cyc), 32'(t0 + 1));
        checkOutput("lat1_resp_cycle", 32'(rs_cyc), 32'(t0 + 2));
        checkOutput("lat1_resp_onehot", {28'b0, l1_resp_seen}, 32'h2);
        checkOutput("lat1_resp_data", l1_data_seen, 32'hA5A5_A585);

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(resp_q.size() + mem_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
